// File: rtl/sincos_pkg.sv
// sincos_pkg: shared constants, CORDIC arctangent table and FSM state type for sincos_calculator
package sincos_pkg;
  localparam logic signed [31:0] PI_Q16 = 32'sh0003243F;
  localparam logic signed [31:0] HALF_PI_Q16 = 32'sh00019220;
  localparam logic signed [31:0] CORDIC_K_Q16 = 32'sh00009B75;
  localparam logic [15:0] ATAN_Q16 [0:15] = '{
    16'hC910, 16'h76B2, 16'h3EB7, 16'h1FD6, 16'h0FFB, 16'h07FF, 16'h0400, 16'h0200,
    16'h0100, 16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008, 16'h0004, 16'h0002
  };
  typedef enum logic [1:0] {IDLE, PREP, ITER, DONE} state_t;
endpackage

// File: rtl/sincos_if.sv
// sincos_if: valid/ready angle-in, cos/sin-out bus of sincos_calculator
interface sincos_if;
  logic in_valid, in_ready, out_valid, out_ready, clamped_o;
  logic [31:0] theta, cos_o, sin_o;
  modport master(output in_valid, theta, out_ready, input in_ready, out_valid, cos_o, sin_o, clamped_o);
  modport slave(input in_valid, theta, out_ready, output in_ready, out_valid, cos_o, sin_o, clamped_o);
endinterface

// File: rtl/cordic_rot_stage.sv
// cordic_rot_stage: one combinational rotation-mode CORDIC micro-step, d=1 rotates by +atan(2^-i)
module cordic_rot_stage
  import sincos_pkg::*;
#(
  parameter int W = 34,
  parameter int GUARD_W = 2
) (
  input  logic signed [W-1:0] x,
  input  logic signed [W-1:0] y,
  input  logic signed [W-1:0] z,
  input  logic [3:0]          i,
  input  logic                d,
  output logic signed [W-1:0] x_n,
  output logic signed [W-1:0] y_n,
  output logic signed [W-1:0] z_n
);
  logic signed [W-1:0] atan;
  assign atan = W'(ATAN_Q16[i]) << GUARD_W;
  assign x_n = d ? x - (y >>> i) : x + (y >>> i);
  assign y_n = d ? y + (x >>> i) : y - (x >>> i);
  assign z_n = d ? z - atan : z + atan;
endmodule

// File: rtl/sincos_calculator.sv
// sincos_calculator: iterative CORDIC cos/sin of a Q16.16 angle; SINCOS_RANGE_CHK_EN enables input clamping to [-PI, PI]
module sincos_calculator
  import sincos_pkg::*;
#(
  parameter int ITER = 16,
  parameter int GUARD_W = 2
) (
  input logic clk,
  input logic rst,
  sincos_if.slave bus
);
  localparam int W = 32 + GUARD_W;
  localparam logic signed [W:0] RND = (W+1)'(1) <<< (GUARD_W - 1);
  localparam logic signed [W:0] SMAX = (W+1)'(32'sh7FFFFFFF);
  localparam logic signed [W:0] SMIN = ~SMAX;
  state_t state, state_n;
  logic signed [31:0] theta_r, theta_in, z_fold;
  logic signed [W-1:0] x, y, z, x_s, y_s, z_s;
  logic [3:0] i;
  logic neg, neg_fold, out_valid_r, last;
  logic [31:0] cos_r, sin_r;

  function automatic logic [31:0] round_sat(input logic signed [W-1:0] v, input logic n);
    logic signed [W:0] e, s;
    e = n ? -{v[W-1], v} : {v[W-1], v};
    s = (e + RND) >>> GUARD_W;
    return s > SMAX ? 32'h7FFFFFFF : s < SMIN ? 32'h80000000 : s[31:0];
  endfunction

  assign last = i == 4'(ITER - 1);
  assign neg_fold = theta_r > HALF_PI_Q16 || theta_r < -HALF_PI_Q16;
  assign z_fold = theta_r > HALF_PI_Q16 ? theta_r - PI_Q16 :
                  theta_r < -HALF_PI_Q16 ? theta_r + PI_Q16 : theta_r;
  assign bus.in_ready = state == IDLE && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.cos_o = cos_r;
  assign bus.sin_o = sin_r;

  cordic_rot_stage #(.W(W), .GUARD_W(GUARD_W)) u_stage (
    .x(x), .y(y), .z(z), .i(i), .d(~z[W-1]),
    .x_n(x_s), .y_n(y_s), .z_n(z_s)
  );

`ifdef SINCOS_RANGE_CHK_EN
  logic over, clamp_r, clamp_q;
  assign over = $signed(bus.theta) > PI_Q16 || $signed(bus.theta) < -PI_Q16;
  assign theta_in = $signed(bus.theta) > PI_Q16 ? PI_Q16 :
                    $signed(bus.theta) < -PI_Q16 ? -PI_Q16 : $signed(bus.theta);
  assign bus.clamped_o = clamp_q;
  // clamp flag travels with the job and is published together with the result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clamp_r <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.in_valid) clamp_r <= over;
      if (state == DONE && !out_valid_r) clamp_q <= clamp_r;
    end
`else
  assign theta_in = $signed(bus.theta);
  assign bus.clamped_o = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  // next state; DONE waits for the registered result to be taken
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = bus.in_valid ? PREP : IDLE;
      PREP: state_n = sincos_pkg::ITER;
      sincos_pkg::ITER: state_n = last ? DONE : sincos_pkg::ITER;
      DONE: state_n = out_valid_r && bus.out_ready ? IDLE : DONE;
    endcase
  end

  // datapath: latch angle, fold to [-PI/2, PI/2], rotate, then register rounded result on DONE entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      theta_r <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      neg <= 1'b0;
      out_valid_r <= 1'b0;
      cos_r <= '0;
      sin_r <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) theta_r <= theta_in;
      if (state == PREP) begin
        x <= W'(CORDIC_K_Q16) <<< GUARD_W;
        y <= '0;
        z <= {z_fold, {GUARD_W{1'b0}}};
        i <= '0;
        neg <= neg_fold;
      end
      if (state == sincos_pkg::ITER) begin
        x <= x_s;
        y <= y_s;
        z <= z_s;
        i <= i + 4'd1;
      end
      if (state == DONE && !out_valid_r) begin
        out_valid_r <= 1'b1;
        cos_r <= round_sat(x, neg);
        sin_r <= round_sat(y, neg);
      end else if (out_valid_r && bus.out_ready) out_valid_r <= 1'b0;
    end
endmodule

// File: tb/tb_sincos_calculator.sv
// tb_sincos_calculator: directed table, random angles vs real-math model, hold/reset/clamp sequences
module tb_sincos_calculator;
  localparam int ITER = 16;
  localparam int TOL = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  sincos_if bus();
  sincos_calculator #(.ITER(ITER), .GUARD_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] theta;
    logic [31:0] cos_e;
    logic [31:0] sin_e;
  } vec_t;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_near(input string nm, input logic [31:0] act, input logic [31:0] exp);
    int diff;
    diff = $signed(act) - $signed(exp);
    checks++;
    if ((^act === 1'bx) || diff > TOL || diff < -TOL) begin
      errors++;
      $display("FAIL %s: got %h expected %h (+/-%0d)", nm, act, exp, TOL);
    end
  endtask

  function automatic void model(input logic [31:0] th, output logic [31:0] c, output logic [31:0] s);
    real a;
    a = real'($signed(th)) / 65536.0;
    c = int'($cos(a) * 65536.0);
    s = int'($sin(a) * 65536.0);
  endfunction

  task automatic start_job(input logic [31:0] th);
    int n = 0;
    @(negedge clk);
    bus.theta = th;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_eq("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input string nm, input logic [31:0] th, input logic [31:0] c_e,
                         input logic [31:0] s_e, input logic cl_e, input logic early);
    int lat;
    bus.out_ready = early;
    start_job(th);
    wait_valid(lat);
    chk_eq({nm, " latency"}, 32'(lat), 32'(ITER + 2));
    chk_near({nm, " cos"}, bus.cos_o, c_e);
    chk_near({nm, " sin"}, bus.sin_o, s_e);
    chk_eq({nm, " clamped"}, 32'(bus.clamped_o), 32'(cl_e));
    consume();
  endtask

  initial begin
    vec_t vecs[5];
    logic [31:0] c0, s0, c_e, s_e, th;
    int lat;
    vecs[0] = '{32'h00000000, 32'h00010000, 32'h00000000};
    vecs[1] = '{32'h00019220, 32'h00000000, 32'h00010000};
    vecs[2] = '{32'h0003243F, 32'hFFFF0000, 32'h00000000};
    vecs[3] = '{32'hFFFF36F0, 32'h0000B505, 32'hFFFF4AFB};
    vecs[4] = '{32'hFFFCDBC1, 32'hFFFF0000, 32'h00000000};
    bus.in_valid = 1'b0;
    bus.theta = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("rst cos", bus.cos_o, 32'd0);
    chk_eq("rst sin", bus.sin_o, 32'd0);
    chk_eq("rst clamped", 32'(bus.clamped_o), 32'd0);
    rst = 1'b0;
    #1 chk_eq("post-rst in_ready", 32'(bus.in_ready), 32'd1);

    for (int k = 0; k < 5; k++)
      run_vec($sformatf("vec%0d", k), vecs[k].theta, vecs[k].cos_e, vecs[k].sin_e, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      th = 32'(int'($urandom_range(411774)) - 205887);
      model(th, c_e, s_e);
      run_vec($sformatf("rnd%0d th=%h", k, th), th, c_e, s_e, 1'b0, 1'(k % 2));
    end

    start_job(32'h00019220);
    wait_valid(lat);
    chk_eq("hold latency", 32'(lat), 32'(ITER + 2));
    c0 = bus.cos_o;
    s0 = bus.sin_o;
    chk_near("hold sin", s0, 32'h00010000);
    bus.theta = 32'h00000000;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_eq("hold out_valid", 32'(bus.out_valid), 32'd1);
      chk_eq("hold in_ready", 32'(bus.in_ready), 32'd0);
      chk_eq("hold cos", bus.cos_o, c0);
      chk_eq("hold sin stable", bus.sin_o, s0);
    end
    consume();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat);
    chk_eq("after-hold latency", 32'(lat), 32'(ITER + 2));
    chk_near("after-hold cos", bus.cos_o, 32'h00010000);
    chk_near("after-hold sin", bus.sin_o, 32'h00000000);
    consume();

    start_job(32'h0003243F);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_eq("iter-rst in_ready", 32'(bus.in_ready), 32'd0);
    chk_eq("iter-rst out_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_eq("iter-rst release in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < ITER + 4; k++) begin
      @(negedge clk);
      chk_eq("discarded job out_valid", 32'(bus.out_valid), 32'd0);
    end
    run_vec("post-rst vec", 32'hFFFF36F0, 32'h0000B505, 32'hFFFF4AFB, 1'b0, 1'b0);

    start_job(32'h00000000);
    wait_valid(lat);
    chk_eq("done out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_eq("done-rst out_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("done-rst in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk_eq("done-rst release in_ready", 32'(bus.in_ready), 32'd1);

`ifdef SINCOS_RANGE_CHK_EN
    run_vec("clamp +4", 32'h00040000, 32'hFFFF0000, 32'h00000000, 1'b1, 1'b0);
    run_vec("clamp -4", 32'hFFFC0000, 32'hFFFF0000, 32'h00000000, 1'b1, 1'b0);
    run_vec("in-range after clamp", 32'h00000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0);
`else
    bus.out_ready = 1'b0;
    start_job(32'h00040000);
    wait_valid(lat);
    chk_eq("no-clamp latency", 32'(lat), 32'(ITER + 2));
    chk_eq("no-clamp clamped", 32'(bus.clamped_o), 32'd0);
    consume();
    run_vec("in-range after out-of-range", 32'h00000000, 32'h00010000, 32'h00000000, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
